// File: rtl/lsu_ctrl.sv
// Load/store unit controller: sequences one core memory request at a time onto a
// single-port RAM, splitting halfword stores into two byte beats and extending loads.
module lsu_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_func,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] ram_addr,
   output logic [1:0]  ram_addr10,
   output logic        ram_we,
   output logic        ram_oe,
   output logic [2:0]  ram_func,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC0 = 2'd1,
      S_ACC1 = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_we;
   logic [2:0]  r_func;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic        r_err;
   logic        w_accept;

   function automatic logic is_illegal(input logic we, input logic [2:0] f, input logic [1:0] a);
      case (f)
         3'b000:         is_illegal = 1'b0;
         3'b001:         is_illegal = a[0];
         3'b010:         is_illegal = (a != 2'b00);
         3'b100, 3'b101: is_illegal = we | (f[0] & a[0]);
         default:        is_illegal = 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] extract(input logic [2:0] f, input logic [1:0] off, input logic [31:0] w);
      logic [31:0] sh;
      logic [7:0]  b;
      logic [15:0] h;
      sh = w >> {off, 3'b000};
      b  = sh[7:0];
      h  = off[1] ? w[31:16] : w[15:0];
      case (f)
         3'b000:  extract = {{24{b[7]}}, b};
         3'b001:  extract = {{16{h[15]}}, h};
         3'b010:  extract = w;
         3'b100:  extract = {24'h000000, b};
         3'b101:  extract = {16'h0000, h};
         default: extract = 32'h00000000;
      endcase
   endfunction

   assign w_accept = req_valid && (r_state == S_IDLE);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and RAM strobes; strobes decode the state so reset drops them at once
   always_comb begin
      w_next = r_state;
      ram_we = 1'b0;
      ram_oe = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_next = is_illegal(req_we, req_func, req_addr[1:0]) ? S_RESP : S_ACC0;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_ACC0: begin
            if (r_we) begin
               ram_we = 1'b1;
               w_next = (r_func == 3'b001) ? S_ACC1 : S_RESP;
            end else begin
               ram_oe = 1'b1;
               w_next = S_RESP;
            end
         end
         S_ACC1: begin
            ram_we = 1'b1;
            w_next = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_next = S_IDLE;
            end else begin
               w_next = S_RESP;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Request latch and response capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_func  <= 3'b000;
         r_addr  <= 32'h00000000;
         r_wdata <= 32'h00000000;
         r_rdata <= 32'h00000000;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_we    <= req_we;
         r_func  <= req_func;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
         r_rdata <= 32'h00000000;
         r_err   <= is_illegal(req_we, req_func, req_addr[1:0]);
      end else if ((r_state == S_ACC0) && !r_we) begin
         r_rdata <= extract(r_func, r_addr[1:0], ram_rdata);
      end else begin
         r_rdata <= r_rdata;
      end
   end

   // RAM address/data views of the latched request; the second SH beat targets the next byte
   always_comb begin
      ram_addr  = {2'b00, r_addr[31:2]};
      ram_func  = (r_func == 3'b010) ? 3'b010 : 3'b000;
      if (r_state == S_ACC1) begin
         ram_addr10 = r_addr[1:0] + 2'd1;
         ram_wdata  = {24'h000000, r_wdata[15:8]};
      end else if (r_we && (r_func == 3'b001)) begin
         ram_addr10 = r_addr[1:0];
         ram_wdata  = {24'h000000, r_wdata[7:0]};
      end else begin
         ram_addr10 = r_addr[1:0];
         ram_wdata  = r_wdata;
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: behavioural RAM, response scoreboard, per-scenario tasks.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_func;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;
   logic [1:0]  ram_addr10;
   logic        ram_we, ram_oe;
   logic [2:0]  ram_func;

   logic [31:0] mem [0:1023];
   logic [32:0] exp_q [$];
   logic [12:0] beat_q [$];
   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   lsu_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_func(req_func), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ram_addr(ram_addr), .ram_addr10(ram_addr10), .ram_we(ram_we), .ram_oe(ram_oe),
      .ram_func(ram_func), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   assign ram_rdata = mem[ram_addr[9:0]];

   // RAM model: word or byte-lane write, beats logged as {addr10, func, data byte}
   always @(posedge clk) begin
      if (ram_we) begin
         beat_q.push_back({ram_addr10, ram_func, ram_wdata[7:0]});
         if (ram_func == 3'b010) mem[ram_addr[9:0]] <= ram_wdata;
         else mem[ram_addr[9:0]][8*ram_addr10 +: 8] <= ram_wdata[7:0];
      end
   end

   task automatic do_req(input logic we, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_lat, input int exp_beats, input int hold);
      int lat;
      logic [32:0] e;
      beat_q.delete();
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_func = f; req_addr = a; req_wdata = wd;
      exp_q.push_back({exp_err, exp_rd});
      n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL req_ready_idle a=%h got=%b exp=1", a, req_ready); end
      @(posedge clk); #1 req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk); lat++;
         if (lat == 1 && !exp_err && !we) begin
            n_checks++;
            if (ram_oe !== 1'b1 || ram_addr !== (a >> 2) || ram_addr10 !== a[1:0]) begin
               n_errors++; $display("FAIL load_acc a=%h oe=%b addr=%h a10=%0d exp addr=%h a10=%0d", a, ram_oe, ram_addr, ram_addr10, a >> 2, a[1:0]);
            end
         end
         if (lat == 1 && exp_err) begin
            n_checks++; if (ram_we !== 1'b0 || ram_oe !== 1'b0) begin n_errors++; $display("FAIL err_no_ram we=%b oe=%b exp 0/0", ram_we, ram_oe); end
         end
      end while (!rsp_valid && lat < 10);
      n_checks++; if (lat != exp_lat) begin n_errors++; $display("FAIL latency a=%h got=%0d exp=%0d", a, lat, exp_lat); end
      e = exp_q.pop_front();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e[31:0] || rsp_err !== e[32]) begin
         n_errors++; $display("FAIL response a=%h f=%0d got v=%b d=%h e=%b exp v=1 d=%h e=%b", a, f, rsp_valid, rsp_rdata, rsp_err, e[31:0], e[32]);
      end
      n_checks++; if (beat_q.size() != exp_beats) begin n_errors++; $display("FAIL beat_count a=%h got=%0d exp=%0d", a, beat_q.size(), exp_beats); end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== e[31:0] || req_ready !== 1'b0) begin
            n_errors++; $display("FAIL hold cyc=%0d got v=%b d=%h rdy=%b exp v=1 d=%h rdy=0", i, rsp_valid, rsp_rdata, req_ready, e[31:0]);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_errors++; $display("FAIL back_idle v=%b rdy=%b exp 0/1", rsp_valid, req_ready); end
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || ram_we !== 1'b0 ||
          ram_oe !== 1'b0 || rsp_rdata !== 32'h0 || ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin
         n_errors++; $display("FAIL reset rdy=%b v=%b err=%b we=%b oe=%b rd=%h ra=%h wd=%h exp 1/0/0/0/0/0/0/0",
                              req_ready, rsp_valid, rsp_err, ram_we, ram_oe, rsp_rdata, ram_addr, ram_wdata);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_loads();
      do_req(1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0, 0);
      do_req(1'b0, 3'b101, 32'h102, 32'h0, 32'h000080FF, 1'b0, 2, 0, 0);
      do_req(1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF80FF, 1'b0, 2, 0, 0);
      do_req(1'b0, 3'b010, 32'h100, 32'h0, 32'h80FF1234, 1'b0, 2, 0, 0);
      do_req(1'b0, 3'b100, 32'h101, 32'h0, 32'h00000012, 1'b0, 2, 0, 0);
   endtask

   task automatic test_store_half();
      do_req(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 1'b0, 3, 2, 0);
      n_checks++;
      if (beat_q.size() != 2 || beat_q[0] !== {2'd2, 3'b000, 8'hCD} || beat_q[1] !== {2'd3, 3'b000, 8'hAB}) begin
         n_errors++; $display("FAIL sh_beats n=%0d exp (2,0,CD)(3,0,AB)", beat_q.size());
      end
      do_req(1'b0, 3'b010, 32'h200, 32'h0, 32'hABCD0000, 1'b0, 2, 0, 0);
   endtask

   task automatic test_store_byte_word();
      do_req(1'b1, 3'b000, 32'h301, 32'h1234565A, 32'h0, 1'b0, 2, 1, 0);
      do_req(1'b0, 3'b100, 32'h301, 32'h0, 32'h0000005A, 1'b0, 2, 0, 0);
      do_req(1'b1, 3'b010, 32'h400, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 0);
      n_checks++; if (mem[10'h100] !== 32'hDEADBEEF) begin n_errors++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[10'h100]); end
      do_req(1'b0, 3'b010, 32'h400, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 0);
   endtask

   task automatic test_errors();
      do_req(1'b1, 3'b010, 32'h201, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 0);
      do_req(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 1'b1, 1, 0, 0);
      do_req(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 0);
      do_req(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 0);
      n_checks++; if (mem[10'h80] !== 32'hABCD0000) begin n_errors++; $display("FAIL err_mem_untouched got=%h exp=abcd0000", mem[10'h80]); end
   endtask

   task automatic test_hold();
      do_req(1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0, 5);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_func = 3'b010; req_addr = 32'h500; req_wdata = 32'h11223344;
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (ram_we !== 1'b1) begin n_errors++; $display("FAIL mid_acc0_we got=%b exp=1", ram_we); end
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if (ram_we !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_errors++; $display("FAIL async_drop we=%b rdy=%b v=%b exp 0/1/0", ram_we, req_ready, rsp_valid);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem[10'h140] !== 32'h0) begin
         n_errors++; $display("FAIL post_reset rdy=%b v=%b mem=%h exp 1/0/0", req_ready, rsp_valid, mem[10'h140]);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[10'h40] = 32'h80FF1234;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_func = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
      test_reset();
      test_loads();
      test_store_half();
      test_store_byte_word();
      test_errors();
      test_hold();
      test_reset_mid();
      n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have no parameters; all widths fixed.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  core memory request present.
REQ-005 req_ready  out  1  request accepted when req_valid & req_ready at posedge.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_func  in  3  RV32 funct3: loads LB 000, LH 001, LW 010, LBU 100, LHU 101; stores SB 000, SH 001, SW 010.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, LSB-aligned.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  core consumes response.
REQ-012 rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 rsp_err  out  1  misaligned or unsupported-func request.
REQ-014 ram_addr  out  32  word address = latched byte address >> 2.
REQ-015 ram_addr10  out  2  byte offset of the current RAM beat.
REQ-016 ram_we  out  1  RAM write strobe; RAM commits at the posedge while high.
REQ-017 ram_oe  out  1  RAM read enable; RAM read is combinational.
REQ-018 ram_func  out  3  write width to RAM: only 000 (byte) or 010 (word) driven.
REQ-019 ram_wdata  out  32  store data to RAM, LSB-aligned; RAM applies byte shift.
REQ-020 ram_rdata  in  32  full word returned by RAM.

Function
REQ-021 SHALL implement FSM states IDLE, ACC0, ACC1, RESP.
REQ-022 IDLE: req_ready=1; on handshake latch we/func/addr/wdata; next = RESP with err if the request is illegal, else ACC0.
REQ-023 Illegal: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]=1; undefined func (loads 011/110/111, stores 011-111).
REQ-024 ACC0 load: ram_oe=1, ram_addr10=addr[1:0]; capture ram_rdata at posedge; next RESP.
REQ-025 ACC0 store SB/SW: ram_we=1 for exactly this cycle, ram_func=000/010, ram_wdata=req_wdata; next RESP.
REQ-026 ACC0 store SH: ram_we=1, ram_func=000, ram_addr10=addr[1:0], ram_wdata[7:0]=wdata[7:0]; next ACC1.
REQ-027 ACC1 (SH only): ram_we=1, ram_func=000, ram_addr10=addr[1:0]+1, ram_wdata[7:0]=wdata[15:8]; next RESP.
REQ-028 Load extraction uses the captured word: byte = word[8*off +: 8], half = word[16*off[1] +: 16]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-029 RESP: rsp_valid=1 with rsp_rdata and rsp_err stable; return to IDLE on rsp_ready; hold otherwise.
REQ-030 req_ready=0 in every state except IDLE; no new request is accepted in the cycle rsp_ready is taken.
REQ-031 Outside ACC0/ACC1, ram_we=0 and ram_oe=0; ram_addr, ram_addr10, ram_func and ram_wdata are don't-care but hold their latched values.
REQ-032 Latency from the accept edge to rsp_valid high: 2 cycles for load/SB/SW, 3 for SH, 1 for errors; illegal requests produce no RAM access.

Reset
REQ-033 While rst_n=0: state IDLE; req_ready=1; rsp_valid, rsp_err, ram_we and ram_oe are 0; all data registers are 0.
REQ-034 rst_n assertion mid-ACC0/ACC1 SHALL drop ram_we immediately (asynchronously); the in-flight request is discarded and no response is issued.

Verification
REQ-035 LB addr 0x103, RAM word 0x80FF1234 -> ram_addr=0x40, ram_addr10=3, rsp_rdata=0xFFFFFF80 two cycles after accept.
REQ-036 LHU addr 0x102, word 0x80FF1234 -> rsp_rdata=0x000080FF; LH from the same address -> 0xFFFF80FF.
REQ-037 SH addr 0x202, wdata 0xABCD -> two consecutive ram_we beats: (addr10=2, data 0xCD), then (addr10=3, data 0xAB), func=000; rsp_valid on the third cycle, rsp_err=0.
REQ-038 SW addr 0x201 -> rsp_err=1 one cycle after accept; ram_we never asserted; rsp_rdata=0.
REQ-039 Response held with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-040 rst_n pulled low during ACC0 of SW -> ram_we=0 within the same cycle; after release, IDLE with req_ready=1 and rsp_valid=0.
